// File: rtl/mult_fixed_point_seq.sv
// Sequential signed fixed-point multiplier that computes one product bit per clock with shift-add.
// The result is saturated and optionally rounded, then returned through a valid/ready handshake.
module mult_fixed_point_seq #(
  parameter int  INT_BITS   = 8,
  parameter int  FRAC_BITS  = 8,
  parameter int  ROUND      = 0,
  localparam int DATA_WIDTH = INT_BITS + FRAC_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Out,
  output logic                  C,
  output logic                  N,
  output logic                  V,
  output logic                  Z
);

  localparam int ACC_W = 2 * DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [ACC_W-1:0] RND     = (ROUND != 0) ? (ACC_W'(1) << (FRAC_BITS - 1)) : '0;
  localparam logic [ACC_W-1:0] MAX_MAG = (ACC_W'(1) << (DATA_WIDTH - 1)) - ACC_W'(1);
  localparam logic [ACC_W-1:0] MIN_MAG = ACC_W'(1) << (DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

  state_t                  state, state_next;
  logic [ACC_W-1:0]        mcand;
  logic [DATA_WIDTH-1:0]   mplier;
  logic [ACC_W-1:0]        acc;
  logic [CNT_W-1:0]        cnt;
  logic                    sign;

  logic [DATA_WIDTH-1:0]   a_abs, b_abs;
  logic [ACC_W-1:0]        rounded, mag;
  logic [DATA_WIDTH-1:0]   res;
  logic                    sat;
  logic                    last_step;

  // Magnitudes are unsigned, so negating the most negative value is still exact.
  assign a_abs     = A[DATA_WIDTH-1] ? (DATA_WIDTH'(0) - A) : A;
  assign b_abs     = B[DATA_WIDTH-1] ? (DATA_WIDTH'(0) - B) : B;
  assign last_step = (cnt == CNT_W'(DATA_WIDTH));

  // NOTE: the state register uses non-blocking assignment, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: defaults come first, so no path leaves state_next unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)  state_next = MULT;
      MULT:    if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rounded = acc + RND;
    mag     = rounded >> FRAC_BITS;
    sat     = 1'b0;
    res     = sign ? (DATA_WIDTH'(0) - mag[DATA_WIDTH-1:0]) : mag[DATA_WIDTH-1:0];
    if (!sign && (mag > MAX_MAG)) begin
      res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      sat = 1'b1;
    end else if (sign && (mag > MIN_MAG)) begin
      res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      sign   <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      Out    <= '0;
      V      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          mcand  <= {{DATA_WIDTH{1'b0}}, a_abs};
          mplier <= b_abs;
          sign   <= A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1];
          acc    <= '0;
          cnt    <= '0;
        end
        MULT: if (last_step) begin
          Out <= res;
          V   <= sat;
        end else begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign C         = 1'b0;
  assign N         = Out[DATA_WIDTH-1];
  assign Z         = (Out == '0);

endmodule

// File: tb/tb_mult_fixed_point_seq.sv
// Directed bench for mult_fixed_point_seq with a truncating and a rounding instance driven in lockstep.
// It covers the Q7.8 products, saturation corners, the handshake hold and an abort by reset.
module tb_mult_fixed_point_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0, b = '0;

  logic        in_ready0, out_valid0, c0, n0, v0, z0;
  logic [15:0] out0;
  logic        in_ready1, out_valid1, c1, n1, v1, z1;
  logic [15:0] out1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_fixed_point_seq #(.INT_BITS(8), .FRAC_BITS(8), .ROUND(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .A(a), .B(b), .out_valid(out_valid0), .out_ready(out_ready),
    .Out(out0), .C(c0), .N(n0), .V(v0), .Z(z0)
  );

  mult_fixed_point_seq #(.INT_BITS(8), .FRAC_BITS(8), .ROUND(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .A(a), .B(b), .out_valid(out_valid1), .out_ready(out_ready),
    .Out(out1), .C(c1), .N(n1), .V(v1), .Z(z1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the accept edge until out_valid rises, giving up after 40.
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid0 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] exp_out, input logic exp_v);
    check({tag, " out"}, 32'(out0), 32'(exp_out));
    check({tag, " V"},   32'(v0),   32'(exp_v));
    check({tag, " N"},   32'(n0),   32'(exp_out[15]));
    check({tag, " Z"},   32'(z0),   32'(exp_out == 16'h0000));
    check({tag, " C"},   32'(c0),   32'(0));
  endtask

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic [15:0] exp_out0, input logic exp_v0, input logic [15:0] exp_out1);
    int n;
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    check({tag, " in_ready"}, 32'(in_ready0), 32'(1));
    tick();
    in_valid = 1'b0;
    a = ~ta;
    b = 16'h1234;
    wait_done(n);
    check({tag, " latency"}, 32'(n), 32'(17));
    check_result(tag, exp_out0, exp_v0);
    check({tag, " round out"}, 32'(out1), 32'(exp_out1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(out_valid0), 32'(0));
    check({tag, " in_ready back"}, 32'(in_ready0), 32'(1));
  endtask

  initial begin
    int n;
    int pulses;

    // Reset state.
    tick();
    tick();
    check("rst in_ready", 32'(in_ready0), 32'(0));
    check("rst out_valid", 32'(out_valid0), 32'(0));
    check_result("rst", 16'h0000, 1'b0);
    rst_n = 1'b1;
    #1;
    check("release in_ready", 32'(in_ready0), 32'(1));

    // Basic and signed products.
    run_op("basic",   16'h0180, 16'h0200, 16'h0300, 1'b0, 16'h0300);
    run_op("neg",     16'hFE80, 16'h0200, 16'hFD00, 1'b0, 16'hFD00);
    run_op("negneg",  16'hFE80, 16'hFE00, 16'h0300, 1'b0, 16'h0300);

    // Saturation corners.
    run_op("sat pos", 16'h6400, 16'h0200, 16'h7FFF, 1'b1, 16'h7FFF);
    run_op("sat neg", 16'h9C00, 16'h0200, 16'h8000, 1'b1, 16'h8000);
    run_op("min*-1",  16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 16'h7FFF);
    run_op("min*1",   16'h8000, 16'h0100, 16'h8000, 1'b0, 16'h8000);

    // Rounding: truncation gives zero, round-half-up gives one LSB; negative zero is plain zero.
    run_op("rnd pos", 16'h0001, 16'h0080, 16'h0000, 1'b0, 16'h0001);
    run_op("rnd neg", 16'hFFFF, 16'h0080, 16'h0000, 1'b0, 16'hFFFF);

    // Handshake: in_valid held high with other operands through MULT and a 5-cycle DONE stall.
    a = 16'h0180;
    b = 16'h0200;
    in_valid = 1'b1;
    tick();
    a = 16'h6400;
    b = 16'h7000;
    wait_done(n);
    check("hs latency", 32'(n), 32'(17));
    check_result("hs", 16'h0300, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hs hold out", 32'(out0), 32'(16'h0300));
      check("hs hold V", 32'(v0), 32'(0));
      check("hs hold valid", 32'(out_valid0), 32'(1));
      check("hs hold in_ready", 32'(in_ready0), 32'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hs idle in_ready", 32'(in_ready0), 32'(1));
    check("hs idle out held", 32'(out0), 32'(16'h0300));
    run_op("hs next", 16'hFE80, 16'h0200, 16'hFD00, 1'b0, 16'hFD00);

    // Reset asserted mid-operation at counter 7.
    a = 16'h6400;
    b = 16'h0200;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    #1;
    check("abort in_ready", 32'(in_ready0), 32'(0));
    tick();
    check("abort out_valid", 32'(out_valid0), 32'(0));
    check_result("abort", 16'h0000, 1'b0);
    rst_n = 1'b1;
    #1;
    check("abort release in_ready", 32'(in_ready0), 32'(1));
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid0) pulses++;
    end
    check("abort no pulse", 32'(pulses), 32'(0));
    run_op("after abort", 16'h0180, 16'h0200, 16'h0300, 1'b0, 16'h0300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
